// File: rtl/router_pkt_reg.sv
// Datapath register stage of the 1x3 router: header latch, FIFO byte forwarding
// with a one-byte hold slot for FIFO-full stalls, and running XOR parity check.
module router_pkt_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] dout_reg;
    logic [DATA_WIDTH-1:0] header_byte_reg;
    logic [DATA_WIDTH-1:0] hold_byte_reg;
    logic [DATA_WIDTH-1:0] int_parity_reg;
    logic [DATA_WIDTH-1:0] pkt_parity_reg;
    logic                  parity_done_reg;
    logic                  low_pkt_valid_reg;
    logic                  err_reg;

    // Address 3 is not a valid destination, so such a header never replaces the latched one.
    logic header_load;
    assign header_load = detect_add && pkt_valid && (data_in[1:0] != 2'b11);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            dout_reg          <= '0;
            header_byte_reg   <= '0;
            hold_byte_reg     <= '0;
            int_parity_reg    <= '0;
            pkt_parity_reg    <= '0;
            parity_done_reg   <= 1'b0;
            low_pkt_valid_reg <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            if (header_load)
                header_byte_reg <= data_in;

            if (lfd_state)
                dout_reg <= header_byte_reg;
            else if (ld_state && !fifo_full)
                dout_reg <= data_in;
            else if (ld_state && fifo_full)
                hold_byte_reg <= data_in;
            else if (laf_state)
                dout_reg <= hold_byte_reg;

            // The byte parked in hold_byte is accumulated here, not again when replayed.
            if (detect_add)
                int_parity_reg <= '0;
            else if (lfd_state)
                int_parity_reg <= int_parity_reg ^ header_byte_reg;
            else if (ld_state && pkt_valid && !full_state)
                int_parity_reg <= int_parity_reg ^ data_in;

            if (detect_add)
                pkt_parity_reg <= '0;
            else if (ld_state && !pkt_valid)
                pkt_parity_reg <= data_in;

            if (rst_int_reg)
                low_pkt_valid_reg <= 1'b0;
            else if (ld_state && !pkt_valid)
                low_pkt_valid_reg <= 1'b1;

            if (detect_add)
                parity_done_reg <= 1'b0;
            else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid_reg && !parity_done_reg))
                parity_done_reg <= 1'b1;

            if (detect_add)
                err_reg <= 1'b0;
            else if (rst_int_reg)
                err_reg <= (int_parity_reg != pkt_parity_reg);
        end
    end

    assign dout          = dout_reg;
    assign parity_done   = parity_done_reg;
    assign low_pkt_valid = low_pkt_valid_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed bench for router_pkt_reg: drives FSM control sequences by hand and
// checks dout against a queue of expected bytes plus the status flags.
module tb_router_pkt_reg;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    router_pkt_reg #(.DATA_WIDTH(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic da, input logic lfd, input logic ld, input logic laf,
                        input logic fs, input logic rir, input logic pv, input logic ff,
                        input logic [7:0] din);
        @(negedge clock);
        detect_add  = da;
        lfd_state   = lfd;
        ld_state    = ld;
        laf_state   = laf;
        full_state  = fs;
        rst_int_reg = rir;
        pkt_valid   = pv;
        fifo_full   = ff;
        data_in     = din;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic check_dout(input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard_empty observed=%h expected=none", tag, dout);
        end else begin
            exp = sb.pop_front();
            chk(tag, dout, exp);
        end
    endtask

    // Header, three payload bytes, parity byte, then CHECK_PARITY_ERROR; caller checks err.
    task automatic run_packet(input string name, input logic [7:0] h, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input logic [7:0] par);
        step(1, 0, 0, 0, 0, 0, 1, 0, h);
        chk({name, "_detect_err"}, {7'b0, err}, 8'h00);
        sb.push_back(h);
        step(0, 1, 0, 0, 0, 0, 1, 0, a);
        check_dout({name, "_dout_hdr"});
        sb.push_back(a);
        step(0, 0, 1, 0, 0, 0, 1, 0, a);
        check_dout({name, "_dout_p0"});
        sb.push_back(b);
        step(0, 0, 1, 0, 0, 0, 1, 0, b);
        check_dout({name, "_dout_p1"});
        chk({name, "_pdone_mid"}, {7'b0, parity_done}, 8'h00);
        sb.push_back(c);
        step(0, 0, 1, 0, 0, 0, 1, 0, c);
        check_dout({name, "_dout_p2"});
        sb.push_back(par);
        step(0, 0, 1, 0, 0, 0, 0, 0, par);
        check_dout({name, "_dout_par"});
        chk({name, "_pdone"}, {7'b0, parity_done}, 8'h01);
        chk({name, "_lowpv"}, {7'b0, low_pkt_valid}, 8'h01);
        idle();
        step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        chk({name, "_lowpv_clr"}, {7'b0, low_pkt_valid}, 8'h00);
    endtask

    initial begin
        resetn = 1'b1;
        detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
        full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0; data_in = 8'h00;

        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            resetn = 1'b0;
            {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, pkt_valid, fifo_full} = 8'($urandom);
            data_in = 8'($urandom);
            @(posedge clock);
            #1;
        end
        chk("rst_dout", dout, 8'h00);
        chk("rst_pdone", {7'b0, parity_done}, 8'h00);
        chk("rst_lowpv", {7'b0, low_pkt_valid}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        idle();

        // Good packet: parity 0D^11^22^33 = 0D
        run_packet("good", 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        chk("good_err", {7'b0, err}, 8'h00);

        // Bad parity byte
        run_packet("bad", 8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF);
        chk("bad_err", {7'b0, err}, 8'h01);
        idle();
        chk("bad_err_hold", {7'b0, err}, 8'h01);

        // FIFO full while 22 is presented; this detect_add also clears err
        step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0D);
        chk("bad_err_clr", {7'b0, err}, 8'h00);
        sb.push_back(8'h0D);
        step(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
        check_dout("full_dout_hdr");
        sb.push_back(8'h11);
        step(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
        check_dout("full_dout_p0");
        sb.push_back(8'h11);
        step(0, 0, 1, 0, 0, 0, 1, 1, 8'h22);
        check_dout("full_dout_held");
        step(0, 0, 0, 0, 1, 0, 1, 1, 8'h33);
        chk("full_dout_fstate", dout, 8'h11);
        sb.push_back(8'h22);
        step(0, 0, 0, 1, 0, 0, 1, 0, 8'h33);
        check_dout("full_dout_laf");
        chk("full_pdone_laf", {7'b0, parity_done}, 8'h00);
        sb.push_back(8'h33);
        step(0, 0, 1, 0, 0, 0, 1, 0, 8'h33);
        check_dout("full_dout_p2");
        sb.push_back(8'h0D);
        step(0, 0, 1, 0, 0, 0, 0, 0, 8'h0D);
        check_dout("full_dout_par");
        chk("full_pdone", {7'b0, parity_done}, 8'h01);
        idle();
        step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        chk("full_err", {7'b0, err}, 8'h00);

        // Invalid address 3 leaves header 0D; then a zero-length packet, parity over header only
        step(1, 0, 0, 0, 0, 0, 1, 0, 8'h07);
        chk("inv_pdone_clr", {7'b0, parity_done}, 8'h00);
        sb.push_back(8'h0D);
        step(0, 1, 0, 0, 0, 0, 0, 0, 8'h0D);
        check_dout("inv_dout_old_hdr");
        sb.push_back(8'h0D);
        step(0, 0, 1, 0, 0, 0, 0, 0, 8'h0D);
        check_dout("zlen_dout_par");
        chk("zlen_pdone", {7'b0, parity_done}, 8'h01);
        idle();
        step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        chk("zlen_err", {7'b0, err}, 8'h00);

        // Reset mid-payload, with parity_done/low_pkt_valid left set beforehand
        step(0, 0, 1, 0, 0, 0, 0, 0, 8'h55);
        step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0E);
        sb.push_back(8'h0E);
        step(0, 1, 0, 0, 0, 0, 1, 0, 8'h99);
        check_dout("mid_dout_hdr");
        step(0, 0, 1, 0, 0, 0, 1, 0, 8'h99);
        @(negedge clock);
        resetn = 1'b0;
        ld_state = 1'b1; pkt_valid = 1'b0; data_in = 8'h77;
        @(posedge clock);
        #1;
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_lowpv", {7'b0, low_pkt_valid}, 8'h00);
        chk("mid_rst_pdone", {7'b0, parity_done}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        idle();

        // Fresh packet after reset: 0A^5A^A5^C3 = 36
        run_packet("post", 8'h0A, 8'h5A, 8'hA5, 8'hC3, 8'h36);
        chk("post_err", {7'b0, err}, 8'h00);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
